// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the core/PIM data-RAM port arbiter.
package ram_arb_pkg;

    localparam int          RAM_ADDR_W      = 10;
    localparam int          RAM_DATA_W      = 32;
    localparam logic [31:0] IO_ADDR_DEFAULT = 32'h0000_0FFC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_C = 1'b0,
        REQ_P = 1'b1
    } req_id_t;

    typedef struct packed {
        logic                    we;
        logic [RAM_ADDR_W-1:0]   addr;
        logic [RAM_DATA_W-1:0]   wdata;
        logic [RAM_DATA_W/8-1:0] wmask;
    } ram_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester that was not served last wins.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == REQ_C) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port data RAM between the core (C) and the PIM engine (P),
// one RAM transaction per accepted request, round-robin on contention.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int          ADDR_W  = RAM_ADDR_W,
    parameter int          DATA_W  = RAM_DATA_W,
    parameter logic [31:0] IO_ADDR = IO_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [31:0]           c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    input  logic [DATA_W/8-1:0]   c_wmask,
    output logic                  c_gnt,
    output logic                  c_done,
    output logic [DATA_W-1:0]     c_rdata,
    output logic                  c_busy,

    input  logic                  p_req,
    input  logic                  p_we,
    input  logic [31:0]           p_addr,
    input  logic [DATA_W-1:0]     p_wdata,
    input  logic [DATA_W/8-1:0]   p_wmask,
    output logic                  p_gnt,
    output logic                  p_done,
    output logic [DATA_W-1:0]     p_rdata,
    output logic                  p_busy,

    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_byteena,
    output logic                  ram_wen,
    output logic                  ram_rden,
    input  logic [DATA_W-1:0]     ram_rdata
);

    arb_state_t        state, state_d;
    req_id_t           owner, rr_last;
    ram_req_t          req_q, req_d;
    logic [DATA_W-1:0] c_rdata_q, p_rdata_q;
    logic [1:0]        eligible, grant, gnt;
    logic              in_issue, wr_done, rd_done, any_done;

    // The IO register address is decoded elsewhere and must never reach the RAM.
    assign eligible = {p_req && (p_addr != IO_ADDR), c_req && (c_addr != IO_ADDR)};

    rr_arbiter2 u_rr (
        .req   (eligible),
        .last  (rr_last),
        .grant (grant)
    );

    assign gnt   = (state == IDLE && reset_n) ? grant : 2'b00;
    assign c_gnt = gnt[0];
    assign p_gnt = gnt[1];

    always_comb begin
        req_d = req_q;
        if (gnt[0]) begin
            req_d.we    = c_we;
            req_d.addr  = c_addr[ADDR_W+1:2];
            req_d.wdata = c_wdata;
            req_d.wmask = c_wmask;
        end else if (gnt[1]) begin
            req_d.we    = p_we;
            req_d.addr  = p_addr[ADDR_W+1:2];
            req_d.wdata = p_wdata;
            req_d.wmask = p_wmask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= REQ_C;
            rr_last   <= REQ_P;
            req_q     <= '0;
            c_rdata_q <= '0;
            p_rdata_q <= '0;
        end else begin
            state <= state_d;
            req_q <= req_d;
            if (|gnt) begin
                owner   <= gnt[1] ? REQ_P : REQ_C;
                rr_last <= gnt[1] ? REQ_P : REQ_C;
            end
            if (rd_done && owner == REQ_C) c_rdata_q <= ram_rdata;
            if (rd_done && owner == REQ_P) p_rdata_q <= ram_rdata;
        end
    end

    always_comb begin
        state_d     = state;
        in_issue    = 1'b0;
        wr_done     = 1'b0;
        rd_done     = 1'b0;
        ram_wen     = 1'b0;
        ram_rden    = 1'b0;
        ram_byteena = '0;
        unique case (state)
            IDLE: begin
                if (|gnt) state_d = ISSUE;
            end
            ISSUE: begin
                in_issue = 1'b1;
                if (req_q.we) begin
                    // A zero mask still completes, it just never strobes the RAM.
                    wr_done     = 1'b1;
                    ram_wen     = |req_q.wmask;
                    ram_byteena = req_q.wmask;
                    state_d     = IDLE;
                end else begin
                    ram_rden = 1'b1;
                    state_d  = RDWAIT;
                end
            end
            RDWAIT: begin
                rd_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign any_done  = wr_done || rd_done;
    assign ram_addr  = req_q.addr;
    assign ram_wdata = req_q.wdata;

    assign c_done = any_done && (owner == REQ_C);
    assign p_done = any_done && (owner == REQ_P);

    // Read data is forwarded in the done cycle and then held from the port register.
    assign c_rdata = (rd_done && owner == REQ_C) ? ram_rdata : c_rdata_q;
    assign p_rdata = (rd_done && owner == REQ_P) ? ram_rdata : p_rdata_q;

    assign c_busy = gnt[0] || (state != IDLE && owner == REQ_C && (in_issue || rd_done));
    assign p_busy = gnt[1] || (state != IDLE && owner == REQ_P && (in_issue || rd_done));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed scenarios plus randomized two-port traffic.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

    localparam logic [31:0] IO = 32'h0000_0FFC;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        c_req, c_we, c_gnt, c_done, c_busy;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [3:0]  c_wmask;
    logic        p_req, p_we, p_gnt, p_done, p_busy;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic [3:0]  p_wmask;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_byteena;
    logic        ram_wen, ram_rden;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    ram_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wmask(c_wmask),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata), .c_busy(c_busy),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_wmask(p_wmask),
        .p_gnt(p_gnt), .p_done(p_done), .p_rdata(p_rdata), .p_busy(p_busy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byteena(ram_byteena),
        .ram_wen(ram_wen), .ram_rden(ram_rden), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [117:0] all_out;
    assign all_out = {c_gnt, c_done, c_busy, c_rdata, p_gnt, p_done, p_busy, p_rdata,
                      ram_addr, ram_wdata, ram_byteena, ram_wen, ram_rden};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Registered-output RAM seen by the DUT
    logic [31:0] ram_mem [0:1023];
    always @(posedge clk) begin
        if (ram_wen) ram_mem[ram_addr] <= merge(ram_mem[ram_addr], ram_wdata, ram_byteena);
        if (ram_rden) ram_rdata <= ram_mem[ram_addr];
    end

    // Reference model: transaction queue, word-addressed memory, round-robin memory
    typedef struct {
        bit          port;
        bit          we;
        logic [9:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
        int          gcyc;
    } txn_t;

    txn_t        sbq[$];
    logic [31:0] ref_mem [0:1023];
    int          free_cyc = 0;
    bit          last_p   = 1'b1;
    logic [31:0] exp_crd  = '0;
    logic [31:0] exp_prd  = '0;

    always @(negedge clk) begin
        txn_t        e;
        logic [31:0] a;
        bit          issue, elig_c, elig_p, eg_c, eg_p, pre_c, pre_p, exp_wen, exp_rden;
        logic [3:0]  exp_be;
        cyc++;
        if (!reset_n) begin
            chk("reset_outputs", 128'(all_out), '0);
            sbq.delete();
            free_cyc = 0;
            last_p   = 1'b1;
            exp_crd  = '0;
            exp_prd  = '0;
        end else begin
            pre_c = (sbq.size() > 0) && !sbq[0].port;
            pre_p = (sbq.size() > 0) && sbq[0].port;

            issue    = (sbq.size() > 0) && (cyc == sbq[0].gcyc + 1);
            exp_wen  = issue && sbq[0].we && (sbq[0].mask != 4'h0);
            exp_rden = issue && !sbq[0].we;
            exp_be   = (issue && sbq[0].we) ? sbq[0].mask : 4'h0;
            chk("ram_strobes", {ram_wen, ram_rden, ram_byteena}, {exp_wen, exp_rden, exp_be});
            if (exp_wen || exp_rden) chk("ram_addr", ram_addr, sbq[0].waddr);
            if (exp_wen) chk("ram_wdata", ram_wdata, sbq[0].wdata);

            if (c_done || p_done) begin
                if (sbq.size() == 0 || (c_done && p_done)) begin
                    chk("done_unexpected", {c_done, p_done}, 2'b00);
                end else begin
                    e = sbq.pop_front();
                    chk("done_port", p_done, e.port);
                    chk("done_latency", cyc - e.gcyc, e.we ? 1 : 2);
                    if (!e.we) begin
                        if (e.port) exp_prd = e.rdata;
                        else        exp_crd = e.rdata;
                    end
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].gcyc + (sbq[0].we ? 1 : 2)) begin
                chk("done_missing", {c_done, p_done}, sbq[0].port ? 2'b01 : 2'b10);
                void'(sbq.pop_front());
            end

            chk("rdata", {c_rdata, p_rdata}, {exp_crd, exp_prd});

            elig_c = c_req && (c_addr != IO);
            elig_p = p_req && (p_addr != IO);
            eg_c   = 1'b0;
            eg_p   = 1'b0;
            if (cyc >= free_cyc) begin
                if (elig_c && (!elig_p || last_p)) eg_c = 1'b1;
                else if (elig_p)                   eg_p = 1'b1;
            end
            chk("gnt", {c_gnt, p_gnt}, {eg_c, eg_p});
            if (eg_c || eg_p) begin
                a       = eg_p ? p_addr : c_addr;
                e.port  = eg_p;
                e.we    = eg_p ? p_we : c_we;
                e.waddr = a[11:2];
                e.wdata = eg_p ? p_wdata : c_wdata;
                e.mask  = eg_p ? p_wmask : c_wmask;
                e.rdata = ref_mem[e.waddr];
                e.gcyc  = cyc;
                if (e.we) ref_mem[e.waddr] = merge(ref_mem[e.waddr], e.wdata, e.mask);
                sbq.push_back(e);
                last_p   = eg_p;
                free_cyc = cyc + (e.we ? 2 : 3);
            end
            chk("busy", {c_busy, p_busy}, {pre_c || eg_c, pre_p || eg_p});
        end
    end

    task automatic wait_gnt(input bit port, input bit io, input int hold, output bit got);
        int lim;
        lim = io ? hold : 60;
        got = 1'b0;
        for (int k = 0; k < lim && !got; k++) begin
            @(negedge clk);
            got = port ? p_gnt : c_gnt;
        end
        if (!io) begin
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL gnt_wait port=%0d: grant=0 after %0d cycles, expected 1", port, lim);
            end
        end
    endtask

    task automatic wait_done(input bit port);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            seen = port ? p_done : c_done;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL done_wait port=%0d: done=0 within 4 cycles, expected 1", port);
        end
    endtask

    task automatic do_c(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input int hold);
        bit got;
        @(posedge clk); #1;
        c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; c_wmask = mask;
        wait_gnt(1'b0, addr == IO, hold, got);
        @(posedge clk); #1;
        c_req = 1'b0;
        if (got) wait_done(1'b0);
    endtask

    task automatic do_p(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input int hold);
        bit got;
        @(posedge clk); #1;
        p_req = 1'b1; p_we = we; p_addr = addr; p_wdata = wdata; p_wmask = mask;
        wait_gnt(1'b1, addr == IO, hold, got);
        @(posedge clk); #1;
        p_req = 1'b0;
        if (got) wait_done(1'b1);
    endtask

    task automatic rand_port(input bit port, input int n);
        logic [31:0] a, d;
        logic [3:0]  m;
        logic        we;
        int          w;
        for (int i = 0; i < n; i++) begin
            w  = int'($urandom_range(0, 15));
            a  = ($urandom() & 32'hFFFF_F003) | 32'(w << 2);
            if ($urandom_range(0, 9) == 0) a = IO;
            we = 1'($urandom_range(0, 1));
            d  = $urandom();
            m  = 4'($urandom_range(0, 15));
            if (port) do_p(we, a, d, m, 3);
            else      do_c(we, a, d, m, 3);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got5;
        reset_n = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_wmask = '0;
        p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0; p_wmask = '0;
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] <= (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
            ref_mem[i] =  (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Contention straight out of reset: C first, then strict alternation
        fork
            begin do_c(1'b0, 32'h0000_0010, '0, '0, 0); do_c(1'b0, 32'h0000_0014, '0, '0, 0); end
            begin do_p(1'b0, 32'h0000_0020, '0, '0, 0); do_p(1'b0, 32'h0000_0024, '0, '0, 0); end
        join

        // Full-word write then read back through the same port
        do_c(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0);
        do_c(1'b0, 32'h0000_0100, '0, '0, 0);

        // Single-byte write from P, then read it back
        do_p(1'b1, 32'h0000_0204, 32'h00AA_0000, 4'b0100, 0);
        do_p(1'b0, 32'h0000_0204, '0, '0, 0);

        // Zero-mask write leaves memory untouched
        do_c(1'b1, 32'h0000_0008, 32'h1234_5678, 4'h0, 0);
        do_c(1'b0, 32'h0000_0008, '0, '0, 0);

        // IO-address requests are never granted; P still gets through
        fork
            do_c(1'b0, IO, '0, '0, 10);
            begin @(posedge clk); do_p(1'b0, 32'h0000_0204, '0, '0, 0); end
        join
        do_c(1'b1, IO, 32'hFFFF_FFFF, 4'hF, 10);

        // Reset asserted during the read-wait cycle of a P read
        @(posedge clk); #1;
        p_req = 1'b1; p_we = 1'b0; p_addr = 32'h0000_0100; p_wmask = '0;
        wait_gnt(1'b1, 1'b0, 0, got5);
        @(posedge clk); #1;
        p_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1 chk("async_reset_outputs", 128'(all_out), '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        fork
            do_c(1'b0, 32'h0000_0040, '0, '0, 0);
            do_p(1'b0, 32'h0000_0044, '0, '0, 0);
        join

        // Randomized traffic from both ports
        fork
            rand_port(1'b0, 40);
            rand_port(1'b1, 40);
        join

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 128'(sbq.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
